// File: rtl/bus_pkg.sv
// Shared types for the bus initiator: FSM state encoding, the latched bus
// command record and the default grant-timeout budget.
package bus_pkg;

  localparam int unsigned BUS_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } bus_init_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_cmd_t;

endpackage

// File: rtl/spi_bus_initiator_if.sv
// Peripheral bus (req/gnt/rvalid) between one initiator and a responder.
//   master : drives req/we/be/addr/wdata, receives gnt/rvalid/rdata
//   slave  : the responder view
interface spi_bus_initiator_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/spi_bus_initiator_timeout_counter.sv
// Clearable, enabled, saturating up-counter used as the grant/response
// timeout. o_expired is high while the count sits at TIMEOUT_CYCLES-1.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clr      : restart from zero (wins over i_en)
//   i_en       : count one step per cycle
//   o_expired  : final count reached
module bus_timeout_counter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_expired;

  assign w_expired = (r_count == LAST);
  assign o_expired = w_expired;

  // Holding at LAST instead of wrapping keeps o_expired asserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/spi_bus_initiator.sv
// Bus initiator: turns one upstream command into one single bus transfer
// and returns exactly one response. A transfer that is never granted (or
// never answered) ends in an error response after TIMEOUT_CYCLES.
//   clk, rst_n            : clock, synchronous active-low reset
//   i_cmd_*/o_cmd_ready   : command channel (valid/ready)
//   o_rsp_*/i_rsp_ready   : response channel (valid/ready)
//   bus                   : peripheral bus, master side
//
// state | meaning
// IDLE  | ready for a command
// REQ   | req driven, waiting for gnt
// WAIT  | granted, waiting for rvalid
// RSP   | response held until rsp_ready
module spi_bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  input  logic [3:0]  i_cmd_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  spi_bus_initiator_if.master bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_RSP  = ST_RSP;

  logic [1:0]  r_state;
  bus_cmd_t    r_cmd;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_clr;
  logic        w_en;
  logic        w_expired;

  // The counter restarts on grant so WAIT gets its own full budget.
  assign w_clr = (r_state == S_IDLE) || ((r_state == S_REQ) && bus.gnt);
  assign w_en  = (r_state == S_REQ) || (r_state == S_WAIT);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_cmd.we    <= i_cmd_we;
            r_cmd.addr  <= i_cmd_addr;
            r_cmd.wdata <= i_cmd_wdata;
            r_cmd.be    <= i_cmd_be;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          // A grant on the final count still completes normally.
          if (bus.gnt) begin
            r_state <= S_WAIT;
          end else if (w_expired) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_WAIT: begin
          if (bus.rvalid) begin
            r_rsp_rdata <= r_cmd.we ? 32'h0 : bus.rdata;
            r_rsp_err   <= 1'b0;
            r_state     <= S_RSP;
          end else if (w_expired) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RSP);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  assign bus.req   = (r_state == S_REQ);
  assign bus.we    = r_cmd.we;
  assign bus.be    = r_cmd.be;
  assign bus.addr  = r_cmd.addr;
  assign bus.wdata = r_cmd.wdata;

endmodule

// File: tb/tb_spi_bus_initiator.sv
module tb_spi_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        cmd_valid;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_ready;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_bus_initiator_if bus16 ();
  spi_bus_initiator_if bus4 ();

  logic        rdy16, rspv16, rspe16, rdy4, rspv4, rspe4;
  logic [31:0] rspd16, rspd4;

  assign bus16.gnt    = gnt & ~sel;
  assign bus16.rvalid = rvalid & ~sel;
  assign bus16.rdata  = rdata;
  assign bus4.gnt     = gnt & sel;
  assign bus4.rvalid  = rvalid & sel;
  assign bus4.rdata   = rdata;

  spi_bus_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmd_valid & ~sel), .o_cmd_ready(rdy16),
    .i_cmd_we(cmd_we), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_be(cmd_be),
    .o_rsp_valid(rspv16), .i_rsp_ready(rsp_ready & ~sel),
    .o_rsp_rdata(rspd16), .o_rsp_err(rspe16),
    .bus(bus16)
  );

  spi_bus_initiator #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmd_valid & sel), .o_cmd_ready(rdy4),
    .i_cmd_we(cmd_we), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_be(cmd_be),
    .o_rsp_valid(rspv4), .i_rsp_ready(rsp_ready & sel),
    .o_rsp_rdata(rspd4), .o_rsp_err(rspe4),
    .bus(bus4)
  );

  // View of whichever instance is under test
  logic        w_ready, w_rspv, w_rspe, w_req, w_we;
  logic [31:0] w_rspd, w_addr, w_wdata;
  logic [3:0]  w_be;
  assign w_ready = sel ? rdy4 : rdy16;
  assign w_rspv  = sel ? rspv4 : rspv16;
  assign w_rspe  = sel ? rspe4 : rspe16;
  assign w_rspd  = sel ? rspd4 : rspd16;
  assign w_req   = sel ? bus4.req : bus16.req;
  assign w_we    = sel ? bus4.we : bus16.we;
  assign w_addr  = sel ? bus4.addr : bus16.addr;
  assign w_wdata = sel ? bus4.wdata : bus16.wdata;
  assign w_be    = sel ? bus4.be : bus16.be;

  // One complete transfer, starting and ending at a negedge.
  // gnt_delay = number of REQ cycles without gnt before gnt is given.
  // Reference: a grant within the budget completes, otherwise req is held
  // for the full budget and an error with zero data is returned.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int gnt_delay, input logic [31:0] rd_val,
                        input int rsp_wait, input bit hold_next);
    int          t;
    int          n_req;
    bit          granted;
    bit          exp_err;
    int          exp_n;
    logic [31:0] exp_rd;
    t       = sel ? 4 : 16;
    exp_err = (gnt_delay >= t);
    exp_n   = exp_err ? t : gnt_delay + 1;
    exp_rd  = (exp_err || we) ? 32'h0 : rd_val;

    n_checks++;
    if (w_ready !== 1'b1 || w_rspv !== 1'b0 || w_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle: cmd_ready=%0b rsp_valid=%0b req=%0b, want 1 0 0", w_ready, w_rspv, w_req);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = $urandom_range(0, 1); cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_be = 4'($urandom);

    n_req = 0;
    granted = 1'b0;
    while (w_req === 1'b1 && n_req < 40) begin
      n_checks++;
      if ({w_we, w_addr, w_wdata, w_be} !== {we, addr, wdata, be} || w_ready !== 1'b0 || w_rspv !== 1'b0) begin
        n_fail++;
        $display("FAIL bus_hold: we=%0b addr=%h wdata=%h be=%h ready=%0b rspv=%0b, want we=%0b addr=%h wdata=%h be=%h ready=0 rspv=0",
                 w_we, w_addr, w_wdata, w_be, w_ready, w_rspv, we, addr, wdata, be);
      end
      if (n_req == gnt_delay) begin
        gnt = 1'b1;
        granted = 1'b1;
      end
      n_req++;
      @(negedge clk);
      gnt = 1'b0;
    end

    n_checks++;
    if (n_req != exp_n) begin
      n_fail++;
      $display("FAIL req_cycles: got %0d, want %0d", n_req, exp_n);
    end

    if (granted) begin
      n_checks++;
      if (w_req !== 1'b0 || w_rspv !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_state: req=%0b rsp_valid=%0b, want 0 0", w_req, w_rspv);
      end
      rvalid = 1'b1;
      rdata  = rd_val;
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = $urandom;
    end

    n_checks++;
    if (w_rspv !== 1'b1 || w_rspe !== exp_err || w_rspd !== exp_rd) begin
      n_fail++;
      $display("FAIL rsp: valid=%0b err=%0b rdata=%h, want 1 %0b %h", w_rspv, w_rspe, w_rspd, exp_err, exp_rd);
    end

    // Backpressure, with stray gnt/rvalid that must be ignored
    for (int i = 0; i < rsp_wait; i++) begin
      if (hold_next) begin
        cmd_valid = 1'b1;
        cmd_addr  = $urandom;
      end
      gnt    = 1'($urandom_range(0, 1));
      rvalid = 1'($urandom_range(0, 1));
      rdata  = $urandom;
      @(negedge clk);
      n_checks++;
      if (w_rspv !== 1'b1 || w_rspe !== exp_err || w_rspd !== exp_rd || w_ready !== 1'b0 || w_req !== 1'b0) begin
        n_fail++;
        $display("FAIL rsp_hold: valid=%0b err=%0b rdata=%h ready=%0b req=%0b, want 1 %0b %h 0 0",
                 w_rspv, w_rspe, w_rspd, w_ready, w_req, exp_err, exp_rd);
      end
    end
    gnt = 1'b0;
    rvalid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (w_rspv !== 1'b0 || w_ready !== 1'b1 || w_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_done: rsp_valid=%0b cmd_ready=%0b req=%0b, want 0 1 0", w_rspv, w_ready, w_req);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_checks++;
    if ({rdy16, rspv16, rspd16, rspe16, bus16.req, bus16.we, bus16.be, bus16.addr, bus16.wdata} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL %s: ready=%0b rspv=%0b rdata=%h err=%0b req=%0b we=%0b be=%h addr=%h wdata=%h, want 1 0 0 0 0 0 0 0 0",
               name, rdy16, rspv16, rspd16, rspe16, bus16.req, bus16.we, bus16.be, bus16.addr, bus16.wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_be = '0; rsp_ready = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset16");
    n_checks++;
    if ({rdy4, rspv4, rspd4, rspe4, bus4.req, bus4.addr} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset4: ready=%0b rspv=%0b rdata=%h err=%0b req=%0b addr=%h, want 1 0 0 0 0 0",
               rdy4, rspv4, rspd4, rspe4, bus4.req, bus4.addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_release");
  endtask

  task automatic test_read();
    sel = 1'b0;
    do_txn(1'b0, 32'h0000_0004, 32'h1234_5678, 4'hF, 0, 32'hA5A5_0001, 0, 1'b0);
  endtask

  task automatic test_write();
    sel = 1'b0;
    do_txn(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 32'h7777_1111, 0, 1'b0);
    do_txn(1'b1, 32'h0000_000C, 32'h0BAD_F00D, 4'h3, 3, 32'h5555_AAAA, 1, 1'b0);
  endtask

  task automatic test_unmapped();
    sel = 1'b0;
    do_txn(1'b0, 32'h0000_0FFC, 32'h0, 4'hF, 1000, 32'hFFFF_FFFF, 0, 1'b0);
    do_txn(1'b0, 32'h0000_0FF8, 32'h0, 4'hF, 15, 32'h0000_00F5, 0, 1'b0);
  endtask

  task automatic test_final_grant();
    sel = 1'b1;
    do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 3, 32'hCAFE_0004, 0, 1'b0);
    do_txn(1'b0, 32'h0000_0044, 32'h0, 4'hF, 4, 32'hCAFE_0005, 0, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 2, 32'h3C3C_1234, 5, 1'b1);
    do_txn(1'b1, 32'h0000_0014, 32'h9999_0000, 4'h1, 0, 32'h1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0020; cmd_wdata = 32'h1357_9BDF; cmd_be = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    n_checks++;
    if (bus16.req !== 1'b0 || rspv16 !== 1'b0 || bus16.addr !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL reset_mid_wait: req=%0b rspv=%0b addr=%h, want 0 0 00000020", bus16.req, rspv16, bus16.addr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("reset_mid");
    rvalid = 1'b1;
    rdata  = 32'hBEEF_0001;
    @(negedge clk);
    rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_reset_vals("late_rvalid");
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    bit hold;
    for (int k = 0; k < 30; k++) begin
      hold = (k < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cmd_valid !== 1'b1) sel = 1'($urandom_range(0, 1));
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
             (k % 3 == 0) ? $urandom_range(13, 18) : $urandom_range(0, 6),
             $urandom, $urandom_range(0, 3), hold);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_final_grant();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_bus_initiator.md
# spi_bus_initiator

Bus-side initiator that issues single read/write transfers on the SoC peripheral bus (req/gnt/rvalid handshake) on behalf of an upstream command source, e.g. an external SPI debug/loader frontend. It is the requesting counterpart of the peripheral offset decoders:
- drives `req`/`addr`;
- waits for `gnt`;
- collects `rdata` on `rvalid`;
- returns one response per command.

A grant timeout converts requests to unmapped offsets, which are never granted, into error responses instead of a hang.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, max cycles `req` is held without `gnt` before aborting; legal range ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  32  target byte address
- cmd_wdata  in  32  write data
- cmd_be  in  4  byte enables
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  1 = grant timeout
- req  out  1  bus request
- we  out  1  bus write enable
- be  out  4  bus byte enables
- addr  out  32  bus address
- wdata  out  32  bus write data
- gnt  in  1  bus grant
- rvalid  in  1  bus response valid, one cycle after gnt
- rdata  in  32  bus read data, valid with rvalid

## Operation
FSM states: IDLE, REQ, WAIT, RSP.
- **IDLE:** `cmd_ready`=1. On cmd_valid:
  - latch we/addr/wdata/be into output registers;
  - clear the timeout counter;
  - go to REQ.
- **REQ:** `req`=1; addr/we/wdata/be held stable.
  - If `gnt` is high: go to WAIT.
  - Else if counter = TIMEOUT_CYCLES-1: go to RSP with err=1, rdata=0.
  - Else: counter++.
  - `gnt` in the same cycle as the final count wins; no error.
- **WAIT:** `req`=0.
  - On `rvalid`: latch rdata (reads only; writes store 0), err=0, go to RSP.
  - Without `rvalid`, the counter also runs here. Reaching TIMEOUT_CYCLES-1 gives RSP with err=1.
- **RSP:** `rsp_valid`=1; rsp_rdata/rsp_err stable. On rsp_ready go to IDLE.
- Only one transfer is outstanding. `cmd_ready`=0 in REQ/WAIT/RSP.
- `gnt` outside REQ and `rvalid` outside WAIT are ignored.
- Counter width is $clog2(TIMEOUT_CYCLES); arithmetic is unsigned and saturates, with no wrap.

## Timing
- All outputs are registered or decoded from the registered state only. There are no combinational paths from inputs to outputs.
- Reset values:
  - state IDLE;
  - req=0, we=0, be=0, addr=0, wdata=0;
  - cmd_ready=1;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Latency, for a cmd accepted at edge 0 with gnt in the first REQ cycle and rvalid one cycle later:
  - req high in cycle 1;
  - WAIT in cycle 2;
  - rsp_valid in cycle 3.
- Timeout path: req is held exactly TIMEOUT_CYCLES cycles, then rsp_valid is asserted with rsp_err=1 in the next cycle.
- `req` deasserts in the cycle after the gnt edge.
- rsp_ready high on the first rsp_valid cycle → IDLE next cycle. Back-to-back commands therefore cost 4 cycles each (minimum).
- Reset asserted in any state: the next edge forces the reset values. An in-flight transfer is abandoned and no response is produced. A late rvalid after reset is ignored.

## Structure
- A shared package (bus_pkg) holds:
  - the state enum `bus_init_state_t`;
  - the bus command struct `bus_cmd_t` {we, addr, wdata, be};
  - the default timeout constant.
- One sub-module is natural: `bus_timeout_counter`, a clearable, enabled, saturating counter with a `expired` flag, parameterised by TIMEOUT_CYCLES.

## Test plan
- **Read to mapped register:** cmd read addr 0x0000_0004. Responder gnt in cycle 1, rvalid+rdata=0xA5A5_0001 in cycle 2 → rsp_valid in cycle 3, rsp_rdata=0xA5A5_0001, rsp_err=0.
- **Write:** we=1, addr 0x8, wdata 0xDEAD_BEEF, be=0xF. The bus sees exactly these values while req=1 → rsp_rdata=0, rsp_err=0.
- **Unmapped offset:** addr 0xFFC, gnt never asserted. req high exactly 16 cycles → rsp_err=1, rsp_rdata=0.
- **Grant on final timeout cycle (TIMEOUT_CYCLES=4):** gnt in the 4th REQ cycle → normal completion, err=0.
- **Response backpressure:** rsp_ready low for 5 cycles → rsp_valid, rsp_rdata and rsp_err stay stable, cmd_ready=0, and a pending cmd_valid is not accepted until the cycle after the handshake.
- **Reset mid-operation:** rst_n low for 1 cycle while in WAIT → all outputs at reset values next cycle, no rsp_valid, and the following rvalid is ignored.
